// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helper types for the scoreboarded register file.
package regfile_sb_pkg;

`include "regfile_defs.vh"

    localparam int DEF_DATA_W   = `RF_DATA_W;
    localparam int DEF_ADDR_W   = `RF_ADDR_W;
    localparam int DEF_MAX_PEND = `RF_MAX_PEND;
    localparam int DEF_ZERO_R0  = `RF_ZERO_R0;
    localparam int DEF_BYPASS   = `RF_BYPASS;

    // How the pending-write counter moves in a given cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_step_e;

    // A fresh reservation and a retired reservation in the same cycle cancel out.
    function automatic cnt_step_e cnt_step(input logic set_new, input logic clr_old);
        cnt_step_e step;
        step = CNT_HOLD;
        if (set_new && !clr_old) begin
            step = CNT_INC;
        end else if (clr_old && !set_new) begin
            step = CNT_DEC;
        end
        return step;
    endfunction

endpackage

// File: rtl/regfile_defs.vh
// Processor-wide default geometry and feature switches for the register file.
`ifndef REGFILE_DEFS_VH
`define REGFILE_DEFS_VH

`define RF_DATA_W   16
`define RF_ADDR_W   4
`define RF_MAX_PEND 8
`define RF_ZERO_R0  1
`define RF_BYPASS   1

`endif

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, a running count of
// busy registers, issue back-pressure and per-operand hazard flags.
module regfile_sb_scoreboard #(
    parameter int ADDR_W   = regfile_sb_pkg::DEF_ADDR_W,
    parameter int ZERO_R0  = regfile_sb_pkg::DEF_ZERO_R0,
    parameter int BYPASS   = regfile_sb_pkg::DEF_BYPASS,
    parameter int MAX_PEND = regfile_sb_pkg::DEF_MAX_PEND
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [ADDR_W-1:0] rs0_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic              iss_rdy,
    output logic              busy0,
    output logic              busy1,
    output logic [ADDR_W:0]   pend_cnt
);

    import regfile_sb_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PEND_LIMIT = (ADDR_W + 1)'(MAX_PEND);

    logic [NREGS-1:0] busy;
    logic             iss_is_r0;
    logic             accepted;
    logic             set_new;
    logic             clr_old;
    logic             fwd0;
    logic             fwd1;
    cnt_step_e        step;

    // Back-pressure comes straight from the registered count so it never
    // depends on this cycle's issue request.
    assign iss_rdy = (pend_cnt < PEND_LIMIT);

    // Decide which reservation changes actually alter the busy population;
    // re-issuing a busy register or retiring one that is re-reserved the same
    // cycle leaves the count alone.
    always_comb begin
        iss_is_r0 = (ZERO_R0 != 0) && (iss_addr == '0);
        accepted  = iss_en && iss_rdy && !iss_is_r0;
        set_new   = accepted && !busy[iss_addr];
        clr_old   = w_en && busy[w_addr] && !(accepted && (iss_addr == w_addr));
        step      = cnt_step(set_new, clr_old);
    end

    // Busy vector: writeback clears, issue sets; the later assignment lets a
    // new reservation win over the result it follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (w_en) begin
                busy[w_addr] <= 1'b0;
            end
            if (accepted) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    // Population count kept incrementally; it moves by at most one per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt <= '0;
        end else begin
            case (step)
                CNT_INC: pend_cnt <= pend_cnt + (ADDR_W + 1)'(1);
                CNT_DEC: pend_cnt <= pend_cnt - (ADDR_W + 1)'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // Operand hazards, masked when the awaited result is being forwarded now.
    always_comb begin
        fwd0  = (BYPASS != 0) && w_en && (w_addr == rs0_addr);
        fwd1  = (BYPASS != 0) && w_en && (w_addr == rs1_addr);
        busy0 = busy[rs0_addr] && !fwd0;
        busy1 = busy[rs1_addr] && !fwd1;
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one
// synchronous write port, optional hardwired r0, write-to-read forwarding
// and a pending-write scoreboard for the issue stage.
module regfile_sb #(
    parameter int DATA_W   = regfile_sb_pkg::DEF_DATA_W,
    parameter int ADDR_W   = regfile_sb_pkg::DEF_ADDR_W,
    parameter int ZERO_R0  = regfile_sb_pkg::DEF_ZERO_R0,
    parameter int BYPASS   = regfile_sb_pkg::DEF_BYPASS,
    parameter int MAX_PEND = regfile_sb_pkg::DEF_MAX_PEND
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs0_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] op0,
    output logic [DATA_W-1:0] op1,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_in,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_rdy,
    output logic              busy0,
    output logic              busy1,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];
    logic              wr_ok;
    logic              fwd0;
    logic              fwd1;

    // A write to the hardwired zero register is discarded entirely, so it
    // neither updates storage nor forwards.
    always_comb begin
        wr_ok = w_en && !((ZERO_R0 != 0) && (w_addr == '0));
    end

    // Register storage, cleared as a whole by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[w_addr] <= w_in;
        end
    end

    // Read port 0: zero register first, then forwarded write data, then storage.
    always_comb begin
        fwd0 = (BYPASS != 0) && wr_ok && (w_addr == rs0_addr);
        op0  = mem[rs0_addr];
        if (fwd0) begin
            op0 = w_in;
        end
        if ((ZERO_R0 != 0) && (rs0_addr == '0)) begin
            op0 = '0;
        end
    end

    // Read port 1: same priority as port 0.
    always_comb begin
        fwd1 = (BYPASS != 0) && wr_ok && (w_addr == rs1_addr);
        op1  = mem[rs1_addr];
        if (fwd1) begin
            op1 = w_in;
        end
        if ((ZERO_R0 != 0) && (rs1_addr == '0)) begin
            op1 = '0;
        end
    end

    regfile_sb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_R0  (ZERO_R0),
        .BYPASS   (BYPASS),
        .MAX_PEND (MAX_PEND)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .rs0_addr (rs0_addr),
        .rs1_addr (rs1_addr),
        .iss_rdy  (iss_rdy),
        .busy0    (busy0),
        .busy1    (busy1),
        .pend_cnt (pend_cnt)
    );

    assign stall = busy0 | busy1;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding instance and a non-forwarding instance
// share all inputs; a vector table covers reads, writes, forwarding and
// hazards, and hand sequences cover back-pressure and mid-cycle reset.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [3:0]  rs0_addr;
    logic [3:0]  rs1_addr;
    logic        w_en;
    logic [3:0]  w_addr;
    logic [15:0] w_in;
    logic        iss_en;
    logic [3:0]  iss_addr;

    logic [15:0] op0;
    logic [15:0] op1;
    logic        iss_rdy;
    logic        busy0;
    logic        busy1;
    logic        stall;
    logic [4:0]  pend_cnt;

    logic [15:0] op0_nb;
    logic [15:0] op1_nb;
    logic        iss_rdy_nb;
    logic        busy0_nb;
    logic        busy1_nb;
    logic        stall_nb;
    logic [4:0]  pend_cnt_nb;

    int num_checks = 0;
    int num_fails  = 0;

    typedef struct packed {
        logic [3:0]  rs0;
        logic [3:0]  rs1;
        logic        w_en;
        logic [3:0]  w_addr;
        logic [15:0] w_in;
        logic        iss_en;
        logic [3:0]  iss_addr;
        logic [15:0] op0;
        logic [15:0] op1;
        logic        busy0;
        logic        busy1;
        logic [4:0]  pend;
        logic [15:0] nb_op0;
        logic [15:0] nb_op1;
        logic        nb_busy0;
        logic        nb_busy1;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    vec_t v;

    regfile_sb #(
        .DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1), .MAX_PEND(8)
    ) dut (
        .clk(clk), .reset(reset),
        .rs0_addr(rs0_addr), .rs1_addr(rs1_addr),
        .op0(op0), .op1(op1),
        .w_en(w_en), .w_addr(w_addr), .w_in(w_in),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_rdy(iss_rdy),
        .busy0(busy0), .busy1(busy1), .stall(stall), .pend_cnt(pend_cnt)
    );

    regfile_sb #(
        .DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(0), .MAX_PEND(8)
    ) dut_nb (
        .clk(clk), .reset(reset),
        .rs0_addr(rs0_addr), .rs1_addr(rs1_addr),
        .op0(op0_nb), .op1(op1_nb),
        .w_en(w_en), .w_addr(w_addr), .w_in(w_in),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_rdy(iss_rdy_nb),
        .busy0(busy0_nb), .busy1(busy1_nb), .stall(stall_nb), .pend_cnt(pend_cnt_nb)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [3:0] rs0, input logic [3:0] rs1,
        input logic we, input logic [3:0] wa, input logic [15:0] wd,
        input logic ie, input logic [3:0] ia,
        input logic [15:0] e_op0, input logic [15:0] e_op1,
        input logic e_b0, input logic e_b1, input logic [4:0] e_pend,
        input logic [15:0] e_nop0, input logic [15:0] e_nop1,
        input logic e_nb0, input logic e_nb1
    );
        vec_t r;
        r.rs0 = rs0;  r.rs1 = rs1;
        r.w_en = we;  r.w_addr = wa;  r.w_in = wd;
        r.iss_en = ie; r.iss_addr = ia;
        r.op0 = e_op0; r.op1 = e_op1;
        r.busy0 = e_b0; r.busy1 = e_b1; r.pend = e_pend;
        r.nb_op0 = e_nop0; r.nb_op1 = e_nop1;
        r.nb_busy0 = e_nb0; r.nb_busy1 = e_nb1;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        w_en     = 1'b0;
        w_addr   = 4'd0;
        w_in     = 16'h0000;
        iss_en   = 1'b0;
        iss_addr = 4'd0;
    endtask

    task automatic applyStimulus(input vec_t s);
        rs0_addr = s.rs0;
        rs1_addr = s.rs1;
        w_en     = s.w_en;
        w_addr   = s.w_addr;
        w_in     = s.w_in;
        iss_en   = s.iss_en;
        iss_addr = s.iss_addr;
    endtask

    initial begin
        //               rs0    rs1    we    wa     wd         ie    ia     op0        op1        b0    b1    pend   nb_op0     nb_op1     nb0   nb1
        vecs[0]  = mk(4'd5,  4'd15, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[1]  = mk(4'd3,  4'd0,  1'b1, 4'd3, 16'hEEEE, 1'b0, 4'd0, 16'hEEEE, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[2]  = mk(4'd3,  4'd3,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'hEEEE, 16'hEEEE, 1'b0, 1'b0, 5'd0, 16'hEEEE, 16'hEEEE, 1'b0, 1'b0);
        vecs[3]  = mk(4'd3,  4'd0,  1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 16'hEEEE, 16'h0000, 1'b0, 1'b0, 5'd0, 16'hEEEE, 16'h0000, 1'b0, 1'b0);
        vecs[4]  = mk(4'd0,  4'd0,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[5]  = mk(4'd7,  4'd3,  1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 16'hBEEF, 16'hEEEE, 1'b0, 1'b0, 5'd0, 16'h0000, 16'hEEEE, 1'b0, 1'b0);
        vecs[6]  = mk(4'd7,  4'd7,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 5'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
        vecs[7]  = mk(4'd4,  4'd4,  1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[8]  = mk(4'd3,  4'd4,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'hEEEE, 16'h0000, 1'b0, 1'b1, 5'd1, 16'hEEEE, 16'h0000, 1'b0, 1'b1);
        vecs[9]  = mk(4'd3,  4'd4,  1'b1, 4'd4, 16'h0042, 1'b0, 4'd0, 16'hEEEE, 16'h0042, 1'b0, 1'b0, 5'd0, 16'hEEEE, 16'h0000, 1'b0, 1'b1);
        vecs[10] = mk(4'd4,  4'd4,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0042, 16'h0042, 1'b0, 1'b0, 5'd0, 16'h0042, 16'h0042, 1'b0, 1'b0);
        vecs[11] = mk(4'd4,  4'd4,  1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 16'h0042, 16'h0042, 1'b0, 1'b0, 5'd1, 16'h0042, 16'h0042, 1'b0, 1'b0);
        vecs[12] = mk(4'd4,  4'd4,  1'b1, 4'd4, 16'h0055, 1'b1, 4'd4, 16'h0055, 16'h0055, 1'b0, 1'b0, 5'd1, 16'h0042, 16'h0042, 1'b1, 1'b1);
        vecs[13] = mk(4'd4,  4'd4,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0055, 16'h0055, 1'b1, 1'b1, 5'd1, 16'h0055, 16'h0055, 1'b1, 1'b1);
        vecs[14] = mk(4'd4,  4'd7,  1'b1, 4'd4, 16'h0066, 1'b0, 4'd0, 16'h0066, 16'hBEEF, 1'b0, 1'b0, 5'd0, 16'h0055, 16'hBEEF, 1'b1, 1'b0);
        vecs[15] = mk(4'd9,  4'd4,  1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'h9999, 16'h0066, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h0066, 1'b0, 1'b0);
        vecs[16] = mk(4'd0,  4'd9,  1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h0000, 16'h9999, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h9999, 1'b0, 1'b0);
        vecs[17] = mk(4'd0,  4'd0,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        reset    = 1'b0;
        rs0_addr = 4'd0;
        rs1_addr = 4'd0;
        driveIdle();

        // Reset seen before any clock edge.
        #1 reset = 1'b1;
        #1;
        checkOutput("reset op0", 32'(op0), 32'h0);
        checkOutput("reset op1", 32'(op1), 32'h0);
        checkOutput("reset pend_cnt", 32'(pend_cnt), 32'h0);
        checkOutput("reset iss_rdy", 32'(iss_rdy), 32'h1);
        checkOutput("reset stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(negedge clk);
            applyStimulus(v);
            #1;
            checkOutput($sformatf("v%0d op0", i), 32'(op0), 32'(v.op0));
            checkOutput($sformatf("v%0d op1", i), 32'(op1), 32'(v.op1));
            checkOutput($sformatf("v%0d busy0", i), 32'(busy0), 32'(v.busy0));
            checkOutput($sformatf("v%0d busy1", i), 32'(busy1), 32'(v.busy1));
            checkOutput($sformatf("v%0d stall", i), 32'(stall), 32'(v.busy0 | v.busy1));
            checkOutput($sformatf("v%0d iss_rdy", i), 32'(iss_rdy), 32'h1);
            checkOutput($sformatf("v%0d nb op0", i), 32'(op0_nb), 32'(v.nb_op0));
            checkOutput($sformatf("v%0d nb op1", i), 32'(op1_nb), 32'(v.nb_op1));
            checkOutput($sformatf("v%0d nb busy0", i), 32'(busy0_nb), 32'(v.nb_busy0));
            checkOutput($sformatf("v%0d nb busy1", i), 32'(busy1_nb), 32'(v.nb_busy1));
            checkOutput($sformatf("v%0d nb stall", i), 32'(stall_nb), 32'(v.nb_busy0 | v.nb_busy1));
            checkOutput($sformatf("v%0d nb iss_rdy", i), 32'(iss_rdy_nb), 32'h1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(v.pend));
            checkOutput($sformatf("v%0d nb pend_cnt", i), 32'(pend_cnt_nb), 32'(v.pend));
        end

        // Back-pressure: fill the scoreboard with r1..r8.
        for (int r = 1; r <= 8; r++) begin
            @(negedge clk);
            driveIdle();
            iss_en   = 1'b1;
            iss_addr = 4'(r);
            @(posedge clk);
            #1;
            checkOutput($sformatf("fill r%0d pend_cnt", r), 32'(pend_cnt), 32'(r));
            checkOutput($sformatf("fill r%0d iss_rdy", r), 32'(iss_rdy), (r < 8) ? 32'h1 : 32'h0);
            if (r == 1) begin
                @(negedge clk);
                iss_en   = 1'b1;
                iss_addr = 4'd1;
                @(posedge clk);
                #1;
                checkOutput("reissue r1 pend_cnt", 32'(pend_cnt), 32'h1);
            end
        end

        // Issue to r9 while full is ignored.
        @(negedge clk);
        driveIdle();
        iss_en   = 1'b1;
        iss_addr = 4'd9;
        rs0_addr = 4'd9;
        @(posedge clk);
        #1;
        checkOutput("full issue r9 pend_cnt", 32'(pend_cnt), 32'h8);
        @(negedge clk);
        driveIdle();
        #1;
        checkOutput("full r9 not busy", 32'(busy0), 32'h0);

        // Issue to an already-busy register is still blocked when full.
        @(negedge clk);
        iss_en   = 1'b1;
        iss_addr = 4'd5;
        @(posedge clk);
        #1;
        checkOutput("full reissue r5 pend_cnt", 32'(pend_cnt), 32'h8);

        // Writeback r2 frees a slot.
        @(negedge clk);
        driveIdle();
        w_en     = 1'b1;
        w_addr   = 4'd2;
        w_in     = 16'h2222;
        rs1_addr = 4'd2;
        #1;
        checkOutput("wb r2 busy1", 32'(busy1), 32'h0);
        checkOutput("wb r2 op1", 32'(op1), 32'h2222);
        @(posedge clk);
        #1;
        checkOutput("wb r2 pend_cnt", 32'(pend_cnt), 32'h7);
        checkOutput("wb r2 iss_rdy", 32'(iss_rdy), 32'h1);

        // Retire r1 and r4, leaving r3, r5..r8 pending.
        @(negedge clk);
        w_addr = 4'd1;
        w_in   = 16'h1111;
        @(posedge clk);
        #1;
        checkOutput("wb r1 pend_cnt", 32'(pend_cnt), 32'h6);
        @(negedge clk);
        w_addr = 4'd4;
        w_in   = 16'h4444;
        @(posedge clk);
        #1;
        checkOutput("wb r4 pend_cnt", 32'(pend_cnt), 32'h5);

        // Asynchronous reset between edges.
        @(negedge clk);
        driveIdle();
        rs0_addr = 4'd3;
        rs1_addr = 4'd5;
        #1;
        checkOutput("pre-reset op0", 32'(op0), 32'hEEEE);
        checkOutput("pre-reset stall", 32'(stall), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("mid reset pend_cnt", 32'(pend_cnt), 32'h0);
        checkOutput("mid reset stall", 32'(stall), 32'h0);
        checkOutput("mid reset op0", 32'(op0), 32'h0);
        checkOutput("mid reset iss_rdy", 32'(iss_rdy), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post reset op1", 32'(op1), 32'h0);
        checkOutput("post reset busy1", 32'(busy1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
        $finish;
    end

endmodule
